// File: rtl/wbuf_rd_responder_if.sv
// Weight-buffer port bundle: AGU read request/response, loader write path and status.
// o_par_err exists only when WBUF_PARITY_EN is defined.
`timescale 1ns/1ps
interface wbuf_rd_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_w_addr;
    logic [DATA_W-1:0] o_w_data;
    logic              o_w_valid;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic              i_stat_clr;
    logic              o_addr_err;
    logic [15:0]       o_rd_count;
`ifdef WBUF_PARITY_EN
    logic              o_par_err;
`endif

    modport master (
`ifdef WBUF_PARITY_EN
        input  o_par_err,
`endif
        output i_rd_en, i_w_addr, i_wr_valid, i_wr_addr, i_wr_data, i_stat_clr,
        input  o_w_data, o_w_valid, o_wr_ready, o_addr_err, o_rd_count
    );

    modport slave (
`ifdef WBUF_PARITY_EN
        output o_par_err,
`endif
        input  i_rd_en, i_w_addr, i_wr_valid, i_wr_addr, i_wr_data, i_stat_clr,
        output o_w_data, o_w_valid, o_wr_ready, o_addr_err, o_rd_count
    );
endinterface

// File: rtl/wbuf_rd_responder.sv
// Weight-buffer read responder with loader write port; WBUF_PARITY_EN adds per-word parity.
// Reads: fixed 2-cycle latency, one per cycle, never stalled; writes stall while a read is issued.
`timescale 1ns/1ps
module wbuf_rd_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    wbuf_rd_responder_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_oor;
    logic              wr_oor;
    logic              wr_fire;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;

    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;
    logic              w_vld;
    logic [DATA_W-1:0] w_dat;
    logic              addr_err;
    logic [15:0]       rd_count;

    state_t            state;
    state_t            state_nxt;
    logic              drain_cnt;
    logic              drain_cnt_nxt;
    logic              pipe_busy;

    assign rd_oor  = {1'b0, bus.i_w_addr}  >= DEPTH_L;
    assign wr_oor  = {1'b0, bus.i_wr_addr} >= DEPTH_L;
    assign rd_idx  = bus.i_w_addr[IDX_W-1:0];
    assign wr_idx  = bus.i_wr_addr[IDX_W-1:0];
    // Single port: a read in the same cycle always wins.
    assign wr_fire = bus.i_wr_valid & ~bus.i_rd_en;

    assign bus.o_wr_ready = ~bus.i_rd_en;
    assign bus.o_w_valid  = w_vld;
    assign bus.o_w_data   = w_dat;
    assign bus.o_addr_err = addr_err;
    assign bus.o_rd_count = rd_count;

`ifdef WBUF_PARITY_EN
    logic par_mem [DEPTH];
    logic s1_par;
    logic par_err;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire && !wr_oor) begin
            mem[wr_idx] <= bus.i_wr_data;
`ifdef WBUF_PARITY_EN
            par_mem[wr_idx] <= ^bus.i_wr_data;
`endif
        end
    end

    // Out-of-range reads turn into zero data (and zero parity) at the array port.
    always_ff @(posedge clk) begin
        if (bus.i_rd_en) begin
            s1_dat <= rd_oor ? '0 : mem[rd_idx];
`ifdef WBUF_PARITY_EN
            s1_par <= rd_oor ? 1'b0 : par_mem[rd_idx];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            w_vld  <= 1'b0;
            w_dat  <= '0;
        end else begin
            s1_vld <= bus.i_rd_en;
            w_vld  <= s1_vld;
            if (s1_vld) begin
                w_dat <= s1_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
            rd_count <= '0;
        end else if (bus.i_stat_clr) begin
            addr_err <= 1'b0;
            rd_count <= '0;
        end else begin
            if ((bus.i_rd_en && rd_oor) || (wr_fire && wr_oor)) begin
                addr_err <= 1'b1;
            end
            if (bus.i_rd_en && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

`ifdef WBUF_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else if (bus.i_stat_clr) begin
            par_err <= 1'b0;
        end else if (s1_vld && ((^s1_dat) != s1_par)) begin
            par_err <= 1'b1;
        end
    end
    assign bus.o_par_err = par_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = 1'b0;
        unique case (state)
            IDLE:    if (bus.i_rd_en) state_nxt = BURST;
            BURST:   if (!bus.i_rd_en) state_nxt = DRAIN;
            DRAIN: begin
                if (bus.i_rd_en) begin
                    state_nxt = BURST;
                end else if (drain_cnt) begin
                    state_nxt = IDLE;
                end else begin
                    drain_cnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pipe_busy = (state != IDLE);
    end

    // Status FSM must cover every read still travelling through the pipe.
    a_busy_covers_pipe: assert property (@(posedge clk) disable iff (!rst)
        (s1_vld || w_vld) |-> pipe_busy);

endmodule

// File: tb/tb_wbuf_rd_responder.sv
// Randomized and directed bench for wbuf_rd_responder against a queue/array reference model.
`timescale 1ns/1ps
module tb_wbuf_rd_responder;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wbuf_rd_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    wbuf_rd_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array plus a two-deep queue of issued reads.
    typedef struct {
        bit          v;
        logic [63:0] d;
    } rd_t;

    logic [DATA_W-1:0] m_mem [DEPTH];
    rd_t               dq [$];
    bit                m_vld = 1'b0;
    logic [63:0]       m_dat = '0;
    bit                m_err = 1'b0;
    logic [15:0]       m_cnt = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq.delete();
            m_vld = 1'b0;
            m_dat = '0;
            m_err = 1'b0;
            m_cnt = '0;
        end else begin
            rd_t r;
            rd_t o;
            bit  rd_bad;
            bit  wr_ok;
            rd_bad = int'(bif.i_w_addr) >= DEPTH;
            wr_ok  = bif.i_wr_valid && !bif.i_rd_en;
            r.v = bif.i_rd_en;
            r.d = rd_bad ? 64'd0 : m_mem[bif.i_w_addr];
            dq.push_back(r);
            if (dq.size() == 2) begin
                o = dq.pop_front();
                m_vld = o.v;
                if (o.v) m_dat = o.d;
            end else begin
                m_vld = 1'b0;
            end
            if (wr_ok && int'(bif.i_wr_addr) < DEPTH) m_mem[bif.i_wr_addr] = bif.i_wr_data;
            if (bif.i_stat_clr) begin
                m_err = 1'b0;
                m_cnt = '0;
            end else begin
                if ((bif.i_rd_en && rd_bad) || (wr_ok && int'(bif.i_wr_addr) >= DEPTH)) m_err = 1'b1;
                if (bif.i_rd_en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        check("w_valid",  64'(bif.o_w_valid),  64'(m_vld));
        check("w_data",   bif.o_w_data,        m_dat);
        check("wr_ready", 64'(bif.o_wr_ready), 64'(!bif.i_rd_en));
        check("addr_err", 64'(bif.o_addr_err), 64'(m_err));
        check("rd_count", 64'(bif.o_rd_count), 64'(m_cnt));
    end

    task automatic step(input bit rd, input int ra, input bit wv, input int wa,
                        input logic [63:0] wd, input bit clr);
        @(posedge clk);
        #1;
        bif.i_rd_en    = rd;
        bif.i_w_addr   = ra[ADDR_W-1:0];
        bif.i_wr_valid = wv;
        bif.i_wr_addr  = wa[ADDR_W-1:0];
        bif.i_wr_data  = wd;
        bif.i_stat_clr = clr;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 64'd0, 1'b0);
    endtask

    logic [63:0] lit [4];
    bit          rd;
    bit          wv;
    bit          clr;
    int          ra;
    int          wa;

    initial begin
        lit[0] = 64'h11; lit[1] = 64'h22; lit[2] = 64'h33; lit[3] = 64'h44;
        bif.i_rd_en    = 1'b0;
        bif.i_w_addr   = '0;
        bif.i_wr_valid = 1'b0;
        bif.i_wr_addr  = '0;
        bif.i_wr_data  = '0;
        bif.i_stat_clr = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bif.o_w_valid),  64'd0);
        check("rst_data",  bif.o_w_data,        64'd0);
        check("rst_err",   64'(bif.o_addr_err), 64'd0);
        check("rst_count", 64'(bif.o_rd_count), 64'd0);
`ifdef WBUF_PARITY_EN
        check("rst_par",   64'(bif.o_par_err),  64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 64; i++) step(1'b0, 0, 1'b1, i, {$urandom, $urandom}, 1'b0);

        // Writes 0..3 then a 4-read burst.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b1, i, lit[i], 1'b0);
            @(negedge clk);
            check("t1_ready", 64'(bif.o_wr_ready), 64'd1);
        end
        for (int i = 0; i < 6; i++) begin
            step(i < 4, i, 1'b0, 0, 64'd0, 1'b0);
            @(negedge clk);
            if (i < 2) check("t1_pre_valid", 64'(bif.o_w_valid), 64'd0);
            else begin
                check("t1_valid", 64'(bif.o_w_valid), 64'd1);
                check("t1_data",  bif.o_w_data, lit[i-2]);
            end
        end
        check("t1_count", 64'(bif.o_rd_count), 64'd4);

        // Write held off by a 3-cycle read burst.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i, 1'b1, 10, 64'hBEEF, 1'b0);
            @(negedge clk);
            check("t2_ready_low", 64'(bif.o_wr_ready), 64'd0);
        end
        step(1'b0, 0, 1'b1, 10, 64'hBEEF, 1'b0);
        @(negedge clk);
        check("t2_ready_high", 64'(bif.o_wr_ready), 64'd1);
        step(1'b1, 10, 1'b0, 0, 64'd0, 1'b0);
        idle();
        idle();
        @(negedge clk);
        check("t2_rb_valid", 64'(bif.o_w_valid), 64'd1);
        check("t2_rb_data",  bif.o_w_data, 64'hBEEF);

        // Read-after-write on the next cycle.
        step(1'b0, 0, 1'b1, 5, 64'hAA, 1'b0);
        step(1'b1, 5, 1'b0, 0, 64'd0, 1'b0);
        idle();
        idle();
        @(negedge clk);
        check("t3_valid", 64'(bif.o_w_valid), 64'd1);
        check("t3_data",  bif.o_w_data, 64'hAA);

        // First out-of-range address, then status clear.
        step(1'b1, 4000, 1'b0, 0, 64'd0, 1'b0);
        idle();
        @(negedge clk);
        check("t4_err_set", 64'(bif.o_addr_err), 64'd1);
        idle();
        @(negedge clk);
        check("t4_valid", 64'(bif.o_w_valid), 64'd1);
        check("t4_data",  bif.o_w_data, 64'd0);
        step(1'b0, 0, 1'b0, 0, 64'd0, 1'b1);
        idle();
        @(negedge clk);
        check("t4_err_clr", 64'(bif.o_addr_err), 64'd0);
        check("t4_cnt_clr", 64'(bif.o_rd_count), 64'd0);

        // Reset one cycle into a burst drops the in-flight read.
        step(1'b1, 0, 1'b0, 0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bif.i_rd_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_valid", 64'(bif.o_w_valid), 64'd0);
            @(posedge clk);
        end
        step(1'b1, 1, 1'b0, 0, 64'd0, 1'b0);
        idle();
        @(negedge clk);
        check("t5_lat1_valid", 64'(bif.o_w_valid), 64'd0);
        idle();
        @(negedge clk);
        check("t5_valid", 64'(bif.o_w_valid), 64'd1);
        check("t5_data",  bif.o_w_data, 64'h22);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rd  = $urandom_range(0, 9) < 6;
            wv  = $urandom_range(0, 1) == 1;
            clr = $urandom_range(0, 63) == 0;
            ra  = ($urandom_range(0, 15) == 0) ? 4000 + int'($urandom_range(0, 95)) : int'($urandom_range(0, 63));
            wa  = ($urandom_range(0, 31) == 0) ? 4000 + int'($urandom_range(0, 95)) : int'($urandom_range(0, 63));
            step(rd, ra, wv, wa, {$urandom, $urandom}, clr);
        end
        idle();
        idle();

`ifdef WBUF_PARITY_EN
        step(1'b0, 0, 1'b0, 0, 64'd0, 1'b1);
        idle();
        dut.par_mem[7] = ~dut.par_mem[7];
        step(1'b1, 7, 1'b0, 0, 64'd0, 1'b0);
        idle();
        @(negedge clk);
        check("t6_par_before", 64'(bif.o_par_err), 64'd0);
        idle();
        @(negedge clk);
        check("t6_par_err",  64'(bif.o_par_err), 64'd1);
        check("t6_par_data", bif.o_w_data, m_mem[7]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
